// File: rtl/quad_encoder_gen.sv
// Quadrature encoder and push-button emulator.
// Emits timed Gray-code step bursts and fixed-length active-low presses.
module quad_encoder_gen #(
  parameter int unsigned STEP_PERIOD  = 500_000,
  parameter int unsigned PRESS_CYCLES = 60_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_steps,
  input  logic       btn_req,
  output logic [1:0] Encoder,
  output logic       EncoderBoton,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PRESS
  } state_t;

  localparam logic [26:0] STEP_LAST = 27'(STEP_PERIOD - 1);
  localparam logic [26:0] PRESS_END = 27'(PRESS_CYCLES);

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [1:0]  r_enc;
  logic        r_dir;
  logic [7:0]  r_left;
  logic [26:0] r_cnt;
  logic        r_btn;
  logic        r_done;

  state_t      w_state;
  logic [1:0]  w_phase;
  logic [1:0]  w_enc;
  logic        w_dir;
  logic [7:0]  w_left;
  logic [26:0] w_cnt;
  logic        w_btn;
  logic        w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= 2'd0;
      r_enc   <= 2'b00;
      r_dir   <= 1'b0;
      r_left  <= 8'd0;
      r_cnt   <= 27'd0;
      r_btn   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_enc   <= w_enc;
      r_dir   <= w_dir;
      r_left  <= w_left;
      r_cnt   <= w_cnt;
      r_btn   <= w_btn;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_dir   = r_dir;
    w_left  = r_left;
    w_cnt   = r_cnt;
    w_btn   = 1'b1;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state = S_RUN;
          w_dir   = cmd_dir;
          w_left  = cmd_steps;
          w_cnt   = 27'd0;
        end else if (btn_req) begin
          w_state = S_PRESS;
          w_cnt   = 27'd0;
        end
      end
      S_RUN: begin
        if (r_left == 8'd0) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else if (r_cnt == STEP_LAST) begin
          w_cnt   = 27'd0;
          w_phase = r_dir ? r_phase + 2'd1 : r_phase - 2'd1;
          w_left  = r_left - 8'd1;
          if (r_left == 8'd1) begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt + 27'd1;
        end
      end
      S_PRESS: begin
        // Low for cycles 1..PRESS_CYCLES after accept, released with done.
        if (r_cnt == PRESS_END) begin
          w_done  = 1'b1;
          w_cnt   = 27'd0;
          w_state = S_IDLE;
        end else begin
          w_btn = 1'b0;
          w_cnt = r_cnt + 27'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_enc = 2'b00;
    unique case (w_phase)
      2'd0: w_enc = 2'b00;
      2'd1: w_enc = 2'b10;
      2'd2: w_enc = 2'b11;
      2'd3: w_enc = 2'b01;
      default: w_enc = 2'b00;
    endcase
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign Encoder      = r_enc;
  assign EncoderBoton = r_btn;
  assign done         = r_done;

endmodule
